// File: rtl/uart_full.sv
// Full-duplex 8N1 UART: independent transmitter and receiver sharing one clock.
// The receiver oversamples nothing; it times mid-bit samples from the start edge.
module uart_full #(
  parameter int CLK_FREQ  = 50000000,
  parameter int BAUD_RATE = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx,
  output logic       tx_busy,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_done
);

  localparam logic [31:0] CLKS_PER_BIT = 32'(CLK_FREQ / BAUD_RATE);
  localparam logic [31:0] BIT_LAST     = CLKS_PER_BIT - 32'd1;
  localparam logic [31:0] HALF_LAST    = (CLKS_PER_BIT >> 1) - 32'd1;

  localparam logic [1:0] TX_IDLE  = 2'd0;
  localparam logic [1:0] TX_START = 2'd1;
  localparam logic [1:0] TX_DATA  = 2'd2;
  localparam logic [1:0] TX_STOP  = 2'd3;

  localparam logic [2:0] RX_IDLE  = 3'd0;
  localparam logic [2:0] RX_START = 3'd1;
  localparam logic [2:0] RX_DATA  = 3'd2;
  localparam logic [2:0] RX_STOP  = 3'd3;
  localparam logic [2:0] RX_DONE  = 3'd4;

  logic [1:0]  tx_state_r;
  logic [31:0] tx_cnt_r;
  logic [2:0]  tx_bit_r;
  logic [7:0]  tx_shift_r;

  logic        rx_meta_r;
  logic        rx_sync_r;
  logic [2:0]  rx_state_r;
  logic [31:0] rx_cnt_r;
  logic [2:0]  rx_bit_r;
  logic [7:0]  rx_shift_r;
  logic        rx_good_r;
  logic        rx_armed_r;

  // Transmit FSM: shifts the latched byte out LSB first between start and stop bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state_r <= TX_IDLE;
      tx_cnt_r   <= 32'd0;
      tx_bit_r   <= 3'd0;
      tx_shift_r <= 8'h00;
      tx         <= 1'b1;
      tx_busy    <= 1'b0;
    end else begin
      case (tx_state_r)
        TX_IDLE: begin
          tx_cnt_r <= 32'd0;
          tx_bit_r <= 3'd0;
          if (tx_start) begin
            tx_shift_r <= tx_data;
            tx         <= 1'b0;
            tx_busy    <= 1'b1;
            tx_state_r <= TX_START;
          end else begin
            tx      <= 1'b1;
            tx_busy <= 1'b0;
          end
        end
        TX_START: begin
          if (tx_cnt_r == BIT_LAST) begin
            tx_cnt_r   <= 32'd0;
            tx         <= tx_shift_r[0];
            tx_shift_r <= {1'b0, tx_shift_r[7:1]};
            tx_state_r <= TX_DATA;
          end else begin
            tx_cnt_r <= tx_cnt_r + 32'd1;
          end
        end
        TX_DATA: begin
          if (tx_cnt_r == BIT_LAST) begin
            tx_cnt_r <= 32'd0;
            if (tx_bit_r == 3'd7) begin
              tx         <= 1'b1;
              tx_state_r <= TX_STOP;
            end else begin
              tx         <= tx_shift_r[0];
              tx_shift_r <= {1'b0, tx_shift_r[7:1]};
              tx_bit_r   <= tx_bit_r + 3'd1;
            end
          end else begin
            tx_cnt_r <= tx_cnt_r + 32'd1;
          end
        end
        TX_STOP: begin
          if (tx_cnt_r == BIT_LAST) begin
            tx_cnt_r   <= 32'd0;
            tx         <= 1'b1;
            tx_busy    <= 1'b0;
            tx_state_r <= TX_IDLE;
          end else begin
            tx_cnt_r <= tx_cnt_r + 32'd1;
          end
        end
        default: begin
          tx_state_r <= TX_IDLE;
          tx_cnt_r   <= 32'd0;
          tx         <= 1'b1;
          tx_busy    <= 1'b0;
        end
      endcase
    end
  end

  // Two-flop synchronizer for the asynchronous rx line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_r <= 1'b1;
      rx_sync_r <= 1'b1;
    end else begin
      rx_meta_r <= rx;
      rx_sync_r <= rx_meta_r;
    end
  end

  // Receive FSM: rx_done fires only after the stop bit has fully elapsed, and
  // a framing error disarms start detection until the line returns high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state_r <= RX_IDLE;
      rx_cnt_r   <= 32'd0;
      rx_bit_r   <= 3'd0;
      rx_shift_r <= 8'h00;
      rx_good_r  <= 1'b0;
      rx_armed_r <= 1'b1;
      rx_data    <= 8'h00;
      rx_done    <= 1'b0;
    end else begin
      rx_done <= 1'b0;
      case (rx_state_r)
        RX_IDLE: begin
          rx_cnt_r <= 32'd0;
          rx_bit_r <= 3'd0;
          if (!rx_armed_r) begin
            rx_armed_r <= rx_sync_r;
          end else if (!rx_sync_r) begin
            rx_state_r <= RX_START;
          end else begin
            rx_state_r <= RX_IDLE;
          end
        end
        RX_START: begin
          if (rx_cnt_r == HALF_LAST) begin
            rx_cnt_r   <= 32'd0;
            rx_state_r <= rx_sync_r ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt_r <= rx_cnt_r + 32'd1;
          end
        end
        RX_DATA: begin
          if (rx_cnt_r == BIT_LAST) begin
            rx_cnt_r   <= 32'd0;
            rx_shift_r <= {rx_sync_r, rx_shift_r[7:1]};
            if (rx_bit_r == 3'd7) begin
              rx_state_r <= RX_STOP;
            end else begin
              rx_bit_r <= rx_bit_r + 3'd1;
            end
          end else begin
            rx_cnt_r <= rx_cnt_r + 32'd1;
          end
        end
        RX_STOP: begin
          if (rx_cnt_r == BIT_LAST) begin
            rx_cnt_r   <= 32'd0;
            rx_state_r <= RX_DONE;
            if (rx_sync_r) begin
              rx_data   <= rx_shift_r;
              rx_good_r <= 1'b1;
            end else begin
              rx_good_r  <= 1'b0;
              rx_armed_r <= 1'b0;
            end
          end else begin
            rx_cnt_r <= rx_cnt_r + 32'd1;
          end
        end
        RX_DONE: begin
          if (rx_cnt_r == HALF_LAST) begin
            rx_cnt_r   <= 32'd0;
            rx_done    <= rx_good_r;
            rx_state_r <= RX_IDLE;
          end else begin
            rx_cnt_r <= rx_cnt_r + 32'd1;
          end
        end
        default: begin
          rx_state_r <= RX_IDLE;
          rx_cnt_r   <= 32'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_full.sv
// Directed bench for uart_full: tx looped to rx, with an external rx driver
// for glitch and framing-error frames.
`timescale 1ns/1ps
module tb_uart_full;

  localparam int CPB  = 1041;
  localparam int HALF = 520;

  typedef struct {
    logic       ext;
    logic       inject;
    logic [7:0] data;
    logic       stop;
    int         exp_done;
    logic [7:0] exp_data;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_w;
  logic       tx_busy;
  logic       rx_line;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       sel_ext;
  logic       rx_ext;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  vec_t vecs[5];

  assign rx_line = sel_ext ? rx_ext : tx_w;

  uart_full #(.CLK_FREQ(10000000), .BAUD_RATE(9600)) dut (
    .clk     (clk),
    .rst     (rst),
    .tx_start(tx_start),
    .tx_data (tx_data),
    .tx      (tx_w),
    .tx_busy (tx_busy),
    .rx      (rx_line),
    .rx_data (rx_data),
    .rx_done (rx_done)
  );

  always #50 clk = ~clk;

  always @(posedge clk) begin
    if (rx_done) done_cnt <= done_cnt + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_done(input int budget, output logic seen);
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (rx_done) seen = 1'b1;
    end
  endtask

  // Called at a negedge; starts a frame and checks the tx waveform at mid-bit.
  task automatic send_loop(input logic [7:0] d, input logic inject);
    logic [9:0] exp_w;
    logic [9:0] got_w;
    exp_w = {1'b1, d, 1'b0};
    sel_ext  = 1'b0;
    tx_data  = d;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    check("tx_accept_busy", tx_busy, 1);
    check("tx_start_level", tx_w, 0);
    repeat (HALF) @(negedge clk);
    got_w[0] = tx_w;
    for (int k = 1; k < 10; k++) begin
      if (inject && k == 5) begin
        tx_data  = 8'h0F;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        repeat (CPB - 1) @(negedge clk);
      end else begin
        repeat (CPB) @(negedge clk);
      end
      got_w[k] = tx_w;
    end
    check("tx_waveform", got_w, exp_w);
    repeat (CPB - HALF - 1) @(negedge clk);
    check("tx_busy_last_cycle", tx_busy, 1);
    @(negedge clk);
    check("tx_busy_end", tx_busy, 0);
    check("tx_idle_level", tx_w, 1);
  endtask

  task automatic drive_frame(input logic [7:0] d, input logic stop);
    logic [9:0] bits;
    bits = {stop, d, 1'b0};
    sel_ext = 1'b1;
    for (int k = 0; k < 10; k++) begin
      rx_ext = bits[k];
      repeat (CPB) @(negedge clk);
    end
    rx_ext = 1'b1;
  endtask

  task automatic run_vector(input vec_t v);
    int   base;
    logic seen;
    base = done_cnt;
    if (v.ext) drive_frame(v.data, v.stop);
    else send_loop(v.data, v.inject);
    wait_done(2 * CPB, seen);
    if (seen) begin
      @(negedge clk);
      check("rx_done_width", rx_done, 0);
    end
    check("rx_done_count", done_cnt - base, v.exp_done);
    check("rx_data", rx_data, v.exp_data);
  endtask

  initial begin
    int   base;
    logic seen;
    vec_t last;

    vecs[0] = '{1'b0, 1'b0, 8'hA5, 1'b1, 1, 8'hA5};
    vecs[1] = '{1'b0, 1'b0, 8'h3C, 1'b1, 1, 8'h3C};
    vecs[2] = '{1'b1, 1'b0, 8'h77, 1'b0, 0, 8'h3C};
    vecs[3] = '{1'b1, 1'b0, 8'h5A, 1'b1, 1, 8'h5A};
    vecs[4] = '{1'b0, 1'b1, 8'hC3, 1'b1, 1, 8'hC3};

    rst      = 1'b1;
    tx_start = 1'b0;
    tx_data  = 8'h00;
    sel_ext  = 1'b0;
    rx_ext   = 1'b1;
    @(negedge clk);
    check("reset_tx", tx_w, 1);
    check("reset_busy", tx_busy, 0);
    check("reset_rx_done", rx_done, 0);
    check("reset_rx_data", rx_data, 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 5; i++) run_vector(vecs[i]);

    // short low glitch on rx must be rejected at the start-bit resample
    base    = done_cnt;
    sel_ext = 1'b1;
    rx_ext  = 1'b0;
    repeat (200) @(negedge clk);
    rx_ext = 1'b1;
    wait_done(2 * CPB, seen);
    check("glitch_no_done", done_cnt - base, 0);
    check("glitch_rx_data", rx_data, 8'hC3);

    // reset in the middle of a transmit frame
    sel_ext  = 1'b0;
    tx_data  = 8'h99;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    repeat (4 * CPB) @(negedge clk);
    base = done_cnt;
    rst  = 1'b1;
    #1;
    check("abort_tx", tx_w, 1);
    check("abort_busy", tx_busy, 0);
    check("abort_rx_done", rx_done, 0);
    check("abort_rx_data", rx_data, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    wait_done(2 * CPB, seen);
    check("abort_no_done", done_cnt - base, 0);
    last = '{1'b0, 1'b0, 8'h66, 1'b1, 1, 8'h66};
    run_vector(last);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_full.md
UART_FULL -- requirements
Module: uart_full

Interface
REQ-001 Parameter CLK_FREQ, default 50000000, system clock frequency in Hz.
REQ-002 Parameter BAUD_RATE, default 9600, serial bit rate in bits per second.
REQ-003 The design SHALL use one clock; reset is asynchronous and active-high (ports clk, rst).
REQ-004 clk  input  1  system clock, all logic on its rising edge.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 tx_start  input  1  request to transmit tx_data, sampled each rising clk edge.
REQ-007 tx_data  input  8  byte to transmit, captured when tx_start is accepted.
REQ-008 tx  output  1  serial transmit line, idle high.
REQ-009 tx_busy  output  1  high while a frame is being transmitted.
REQ-010 rx  input  1  serial receive line, asynchronous to clk, idle high.
REQ-011 rx_data  output  8  last correctly received byte, held until the next good frame.
REQ-012 rx_done  output  1  one-cycle pulse when a good frame has been received.

Function
REQ-013 Frame format SHALL be 8N1: start bit (0), 8 data bits LSB first, stop bit (1); no parity.
REQ-014 Bit period SHALL be CLKS_PER_BIT = CLK_FREQ / BAUD_RATE clk cycles, integer division truncating (10 MHz / 9600 = 1041).
REQ-015 TX FSM states SHALL be IDLE, START, DATA, STOP.
REQ-016 In IDLE with tx_start=1, TX SHALL latch tx_data, enter START, and drive tx=0 and tx_busy=1 from the next cycle.
REQ-017 START, each DATA bit and STOP SHALL each last exactly CLKS_PER_BIT cycles; DATA bit index 0..7 drives tx_data[index].
REQ-018 After the last STOP cycle, TX SHALL return to IDLE with tx=1 and tx_busy=0 in the same cycle.
REQ-019 tx_start while tx_busy=1 SHALL be ignored, not queued; a change of tx_data mid-frame SHALL NOT affect the frame.
REQ-020 tx_start held high continuously SHALL start a new frame on the first cycle back in IDLE; frames are back-to-back with no idle gap.
REQ-021 rx SHALL pass through a 2-flop synchronizer, reset value 1, before any use.
REQ-022 RX FSM states SHALL be IDLE, START, DATA, STOP, DONE.
REQ-023 IDLE: a synchronized low on rx SHALL enter START with the bit counter cleared.
REQ-024 START: after CLKS_PER_BIT/2 cycles rx SHALL be resampled; if low, go to DATA; if high, treat as a glitch and return to IDLE with no output.
REQ-025 DATA: sample rx every CLKS_PER_BIT cycles (mid-bit), shifting bits in LSB first; after the 8th sample go to STOP.
REQ-026 STOP: sample rx after CLKS_PER_BIT cycles (mid-stop bit); if 1, load rx_data and go to DONE; if 0 (framing error), discard the byte, leave rx_data unchanged, and go to DONE without flagging.
REQ-027 DONE: wait CLKS_PER_BIT/2 cycles (end of stop bit), pulse rx_done for exactly one cycle for a good frame only, then return to IDLE.
REQ-028 After a framing error, RX SHALL NOT re-arm in IDLE until synchronized rx has been seen high.
REQ-029 rx_done therefore SHALL occur no earlier than the end of the stop bit, so in tx->rx loopback TX is already idle and accepts a new tx_start one cycle after rx_done.
REQ-030 TX and RX SHALL be fully independent; simultaneous operation SHALL be supported.

Reset
REQ-031 While rst=1: tx=1, tx_busy=0, rx_data=8'h00, rx_done=0, both FSMs in IDLE, all counters and shift registers zero, synchronizer flops 1.
REQ-032 Reset asserted mid-frame SHALL abort both directions immediately; no rx_done SHALL be produced for the aborted frame.
REQ-033 After rst deasserts, the first tx_start SHALL be accepted on the next clk edge.

Verification (CLK_FREQ=10000000, BAUD_RATE=9600, tx looped to rx)
REQ-034 Reset 200 ns, tx_data=8'hA5, tx_start for one cycle -> tx waveform 0,1,0,1,0,0,1,0,1,1 at 1041 cycles/bit; rx_done pulses once; rx_data=8'hA5.
REQ-035 One cycle after that rx_done, tx_data=8'h3C, tx_start for one cycle -> frame accepted; rx_data=8'h3C with a single rx_done pulse.
REQ-036 tx_start pulsed mid-frame with a different byte -> ignored; tx_busy timing unchanged; the original byte is received.
REQ-037 rx driven externally with a 200-cycle low glitch -> no rx_done; rx_data unchanged; RX back in IDLE.
REQ-038 rx driven externally with a frame whose stop bit is 0 -> no rx_done; rx_data keeps its previous value; the next good frame 8'h5A is received correctly.
REQ-039 rst asserted in the middle of a TX frame -> tx=1 and tx_busy=0 immediately; no rx_done; the next frame after reset is received correctly.
